// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : opcodes, control encodings, FSM states and control-word struct
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_out_decode.sv
`default_nettype none
// ============================================================================
// mc_out_decode : Moore map from FSM state (plus mem_ready in FETCH) to controls
// Rev 1.0
// ============================================================================
module mc_out_decode
  import mips_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC load only on the cycle the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multicycle MIPS-subset control FSM (state reg + next state)
// Option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps undecoded opcodes, sets illegal
// Rev 1.0
// ============================================================================
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    op,
  input  logic              zf,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              ior_d,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        pc_source,
  output logic              illegal
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) state_d = S_MEM_ADDR;
        else if (op == OPW'(OP_RTYPE))               state_d = S_R_EXEC;
        else if (op == OPW'(OP_ADDI))                state_d = S_I_EXEC;
        else if (op == OPW'(OP_BEQ))                 state_d = S_BRANCH;
        else if (op == OPW'(OP_J))                   state_d = S_JUMP;
        else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      // opcode is still held in the IR here, so it picks load vs store
      S_MEM_ADDR: state_d = (op == OPW'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_en         = ctrl.pc_write | (ctrl.pc_write_cond & zf);
  assign ior_d         = ctrl.ior_d;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ALUOPW'(ctrl.alu_op);
  assign pc_source     = ctrl.pc_source;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : instruction-level reference model plus directed tests
// Rev 1.0
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'b0;
  logic       zf = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, pc_write, pc_write_cond, ior_d, ir_write, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  int n_total = 0;
  int n_pass  = 0;

  multicycle_ctrl #(.OPW(6), .ALUOPW(3)) dut (
    .clk(clk), .reset(reset), .op(op), .zf(zf), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ior_d(ior_d), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // control word: {pw,pwc,iord,irw,mr,mw,rw,rd,m2r,sa,sb[1:0],aop[2:0],ps[1:0]}
  function automatic logic [16:0] cw(input logic pw, pwc, iord, irw, mr, mw, rw, rd, m2r, sa,
                                     input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] ps);
    return {pw, pwc, iord, irw, mr, mw, rw, rd, m2r, sa, sb, aop, ps};
  endfunction

  typedef struct packed {
    logic [16:0] w;
    logic        wt;    // lingers while mem_ready is low
    logic        trap;  // never leaves
    logic        dec;   // dispatch point: opcode determines what follows
  } step_t;

  function automatic step_t st(input logic [16:0] w, input logic wt, trap, dec);
    step_t s;
    s.w = w; s.wt = wt; s.trap = trap; s.dec = dec;
    return s;
  endfunction

  // ---------------- reference model: per-instruction step list ----------------
  step_t       q[$];
  logic        exp_ill = 1'b0;

  always @(negedge clk) begin
    step_t       f;
    logic [16:0] ew;
    logic [18:0] ev, av;
    av = {pc_write, pc_write_cond, ior_d, ir_write, mem_read, mem_write, reg_write,
          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, pc_en, illegal};
    if (!reset) begin
      exp_ill = 1'b0;
      q.delete();
      q.push_back(st(17'd0, 1'b0, 1'b0, 1'b0));
      n_total++;
      if (av === 19'd0) n_pass++;
      else $display("FAIL reset_outputs: got %0h expected 0", av);
    end else begin
      if (q.size() == 0)
        q.push_back(st(cw(1,0,0,1,1,0,0,0,0,0,2'b01,3'b000,2'b00), 1'b1, 1'b0, 1'b0));
      f  = q[0];
      ew = f.w;
      if (f.wt && !mem_ready) begin
        ew[16] = 1'b0;  // no PC load while the fetch is still pending
        ew[13] = 1'b0;  // no IR load either
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      if (f.trap) exp_ill = 1'b1;
`endif
      ev = {ew, ew[16] | (ew[15] & zf), exp_ill};
      n_total++;
      if (av === ev) n_pass++;
      else $display("FAIL cycle_model t=%0t: got %0h expected %0h", $time, av, ev);
      if (!(f.wt && !mem_ready) && !f.trap) begin
        void'(q.pop_front());
        if (f.w[13])  // fetch finished: decode comes next
          q.push_back(st(cw(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00), 1'b0, 1'b0, 1'b1));
        if (f.dec) begin
          case (op)
            6'b100011: begin
              q.push_back(st(cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
              q.push_back(st(cw(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00), 1'b1, 1'b0, 1'b0));
              q.push_back(st(cw(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
            end
            6'b101011: begin
              q.push_back(st(cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
              q.push_back(st(cw(0,0,1,0,0,1,0,0,0,0,2'b00,3'b000,2'b00), 1'b1, 1'b0, 1'b0));
            end
            6'b000000: begin
              q.push_back(st(cw(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00), 1'b0, 1'b0, 1'b0));
              q.push_back(st(cw(0,0,0,0,0,0,1,1,0,0,2'b00,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
            end
            6'b001000: begin
              q.push_back(st(cw(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
              q.push_back(st(cw(0,0,0,0,0,0,1,0,0,0,2'b00,3'b000,2'b00), 1'b0, 1'b0, 1'b0));
            end
            6'b000100:
              q.push_back(st(cw(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01), 1'b0, 1'b0, 1'b0));
            6'b000010:
              q.push_back(st(cw(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10), 1'b0, 1'b0, 1'b0));
            default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
              q.push_back(st(17'd0, 1'b0, 1'b1, 1'b0));
`endif
            end
          endcase
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next one.
  task automatic exec(input logic [5:0] opc, input logic z, input int nf, input int nm,
                      output int cyc, output int nrw, output int nmw, output int rw_at,
                      output logic pcen_br, output logic rdst);
    int   fw, mw;
    logic prev_fetch, fetch, done;
    op = opc; zf = z;
    cyc = 0; nrw = 0; nmw = 0; rw_at = 0; pcen_br = 1'bx; rdst = 1'bx;
    fw = 0; mw = 0; prev_fetch = 1'b0; done = 1'b0;
    while (!done && cyc < 20) begin
      fetch = mem_read && !ior_d;
      if (fetch && !prev_fetch && cyc > 0) done = 1'b1;
      else begin
        mem_ready = 1'b1;
        if (fetch && fw < nf) begin mem_ready = 1'b0; fw++; end
        if (ior_d && mw < nm) begin mem_ready = 1'b0; mw++; end
        cyc++;
        if (reg_write) begin nrw++; rw_at = cyc; rdst = reg_dst; end
        if (mem_write) nmw++;
        if (pc_write_cond) pcen_br = pc_en;
        prev_fetch = fetch;
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int   cyc, nrw, nmw, rw_at, k;
    logic pcb, rd;

    @(posedge clk); #1;
    chk("rst_low_outputs", {mem_read, ir_write, pc_write, reg_write, illegal}, 0);
    reset_cycles(2);
    chk("idle_after_release", {mem_read, ir_write, pc_write, reg_write, mem_write}, 0);
    @(posedge clk); #1;
    chk("first_fetch", {mem_read, ir_write, pc_write, ior_d}, 4'b1110);

    exec(6'b100011, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("lw_cycles", cyc, 5);
    chk("lw_regwrite_cycle", rw_at, 5);
    chk("lw_regwrite_count", nrw, 1);

    exec(6'b100011, 1'b0, 1, 2, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("lw_wait_cycles", cyc, 8);

    exec(6'b101011, 1'b0, 0, 2, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("sw_wait_cycles", cyc, 6);
    chk("sw_memwrite_held", nmw, 3);
    chk("sw_no_regwrite", nrw, 0);

    exec(6'b000100, 1'b1, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_pc_en", pcb, 1);
    exec(6'b000100, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("beq_not_taken_cycles", cyc, 3);
    chk("beq_not_taken_pc_en", pcb, 0);

    exec(6'b000000, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("rtype_cycles", cyc, 4);
    chk("rtype_reg_dst", rd, 1);
    exec(6'b000010, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("jump_cycles", cyc, 3);
    exec(6'b001000, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("addi_cycles", cyc, 4);
    chk("addi_reg_dst", rd, 0);

    exec(6'b111111, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    chk("illegal_trapped", cyc, 20);
    chk("illegal_flag", illegal, 1);
`else
    chk("illegal_nop_cycles", cyc, 2);
    chk("illegal_flag", illegal, 0);
`endif
    chk("illegal_no_writes", nrw + nmw, 0);

    #0 reset = 1'b0;
    #1 chk("reset_clears_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // abort a load mid-access
    op = 6'b100011; mem_ready = 1'b1;
    k = 0;
    while (!(ior_d && mem_read) && k < 10) begin
      @(posedge clk); #1; k++;
    end
    chk("reach_mem_rd", {ior_d, mem_read}, 2'b11);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("abort_outputs", {mem_read, ior_d, reg_write, mem_write}, 0);
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    exec(6'b001000, 1'b0, 0, 0, cyc, nrw, nmw, rw_at, pcb, rd);
    chk("recover_addi_cycles", cyc, 4);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the MIPS-subset datapath. It replaces the single-cycle decode-only control unit with a finite state machine. The FSM steps each instruction through fetch, decode, execute, memory and write-back, and drives per-state enables onto the shared PC, instruction register, register bank, ALU and one shared instruction/data memory. It sits beside the datapath, reads the opcode, ALU zero flag and memory ready, and produces every write-enable and mux select.

## Interface
Parameters:
- `OPW`, 6: opcode width (Instruction[31:26]).
- `ALUOPW`, 3: ALUOp width, feeds ALU_Control.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `op` input OPW: opcode from the instruction register.
- `zf` input 1: ALU zero flag.
- `mem_ready` input 1: memory completed the current access this cycle.
- `pc_en` output 1: PC load, equal to `pc_write | (pc_write_cond & zf)`.
- `pc_write`, `pc_write_cond` output 1: unconditional / branch PC-update qualifiers.
- `ior_d` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_write` output 1: instruction register load.
- `mem_read`, `mem_write` output 1: memory strobes.
- `reg_write`, `reg_dst`, `mem_to_reg` output 1: register bank controls.
- `alu_src_a` output 1: ALU operand A select, 0 = PC, 1 = rs.
- `alu_src_b` output 2: ALU operand B select, 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_op` output ALUOPW: 000 = add, 001 = sub, 010 = funct-decoded.
- `pc_source` output 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` output 1: sticky illegal-opcode flag (see Configuration).

## Operation
States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.

Per-state outputs (Moore; every unlisted output is 0):
- IDLE: all outputs 0; next state FETCH.
- FETCH: mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - If `mem_ready`=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH with ir_write and pc_write held at 0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precomputed into ALUOut). Dispatch on `op`:
  - 100011 (lw) / 101011 (sw) → MEM_ADDR.
  - 000000 → R_EXEC.
  - 001000 (addi) → I_EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - anything else → illegal handling.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, ior_d=1. Wait for `mem_ready`, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, ior_d=1. Hold until `mem_ready`, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.

## Timing
- Reset: asynchronous entry to IDLE, `illegal` cleared, all outputs 0 while `reset`=0. The first FETCH occurs one cycle after release.
- Latency with `mem_ready` always 1:
  - beq, j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
- Each low cycle of `mem_ready` adds exactly one cycle in FETCH, MEM_RD or MEM_WR. Strobes and `ior_d` stay stable for the whole wait.
- `pc_en` is the only output that depends on an input (`zf`), and only in BRANCH. Every other output depends on state and `mem_ready` only.
- Write-enables (`reg_write`, `mem_write`, `ir_write`, `pc_write`) are never asserted in two consecutive states for the same instruction.
- Reset asserted mid-instruction: the FSM aborts immediately. No partial write is allowed in the reset cycle.

## Configuration
- `MULTICYCLE_CTRL_ILLEGAL_TRAP_EN` defined:
  - An undecoded opcode in DECODE goes to TRAP and sets `illegal`=1.
  - TRAP holds all outputs 0 and never leaves until reset.
- Undefined:
  - An undecoded opcode returns from DECODE to FETCH, executing as a 2-cycle NOP.
  - `illegal` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALUOp encodings;
  - alu_src_b and pc_source encodings;
  - the state enumeration.
- One sub-module, `mc_out_decode`: a purely combinational map from state (plus `mem_ready`) to the output vector. The FSM register and next-state logic stay in `multicycle_ctrl`.

## Test plan
- Reset low for 3 cycles, then high, `mem_ready`=1 → all outputs 0 during reset. Cycle 1 IDLE, cycle 2 FETCH with mem_read=1, ir_write=1, pc_write=1.
- op=100011, `mem_ready`=1 → FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. reg_write=1 with mem_to_reg=1 exactly in cycle 5.
- op=101011, `mem_ready` low for 2 cycles in MEM_WR → mem_write held 3 cycles with ior_d=1. Return to FETCH; reg_write never asserted.
- op=000100, zf=1 then zf=0 on the next beq → pc_en=1 with pc_source=01 in BRANCH, then pc_en=0; both complete in 3 cycles.
- op=000000 then op=000010 → R_WB with reg_dst=1 and alu_op=010 in R_EXEC; JUMP with pc_write=1 and pc_source=10.
- op=111111, with and without the macro → the macro build enters TRAP and `illegal`=1 stays set until reset. The non-macro build returns to FETCH after 2 cycles with no writes.
